// File: rtl/regfile_port_arbiter.sv
// Arbitrates NREQ requesters onto a single-access 64x32 register file:
// writes win by default, a starvation counter forces a waiting read through.
module regfile_port_arbiter #(
   parameter int NREQ     = 3,
   parameter int MAX_WAIT = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_write,
   input  logic [6*NREQ-1:0]    req_rd,
   input  logic [6*NREQ-1:0]    req_rs,
   input  logic [6*NREQ-1:0]    req_rt,
   input  logic [32*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      resp_valid,
   output logic [31:0]          resp_rs_data,
   output logic [31:0]          resp_rt_data,
   output logic                 rf_write,
   output logic [5:0]           rf_rd,
   output logic [5:0]           rf_rs,
   output logic [5:0]           rf_rt,
   output logic [31:0]          rf_data_in,
   input  logic [31:0]          rf_rs_out,
   input  logic [31:0]          rf_rt_out,
   output logic                 starve_force
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Handshake: a command transfers in any cycle where req_valid[i] and
   // req_ready[i] are both high; the requester holds its fields until then.

   logic [PW-1:0]   rr_ptr;
   logic [3:0]      wait_cnt;
   logic [NREQ-1:0] resp_pending;

   logic [NREQ-1:0] w_set;
   logic [NREQ-1:0] r_set;
   logic [NREQ-1:0] cand;
   logic [NREQ-1:0] grant;
   logic [PW:0]     idx;
   logic [PW-1:0]   win_idx;
   logic            found;
   logic            force_rd;
   logic            pick_rd;
   logic            rd_grant;

   always_comb begin
      // Masking with rst_n keeps every command pin quiet while reset is held.
      w_set    = req_valid & req_write & {NREQ{rst_n}};
      r_set    = req_valid & ~req_write & {NREQ{rst_n}};
      force_rd = (wait_cnt == MAX_WAIT[3:0]) && (|r_set);
      pick_rd  = force_rd || (~(|w_set) && (|r_set));
      cand     = pick_rd ? r_set : w_set;
      found    = 1'b0;
      win_idx  = '0;
      idx      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = {1'b0, rr_ptr} + k[PW:0];
         if (idx >= NREQ[PW:0]) idx = idx - NREQ[PW:0];
         if (!found && cand[idx[PW-1:0]]) begin
            found   = 1'b1;
            win_idx = idx[PW-1:0];
         end
      end
      grant = '0;
      if (found) grant[win_idx] = 1'b1;
      rd_grant = found && pick_rd;
   end

   always_comb begin
      req_ready    = grant;
      rf_write     = found && !pick_rd;
      rf_rd        = '0;
      rf_data_in   = '0;
      rf_rs        = '0;
      rf_rt        = '0;
      starve_force = force_rd;
      if (found && !pick_rd) begin
         rf_rd      = req_rd[6*win_idx +: 6];
         rf_data_in = req_data[32*win_idx +: 32];
      end
      if (rd_grant) begin
         rf_rs = req_rs[6*win_idx +: 6];
         rf_rt = req_rt[6*win_idx +: 6];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr       <= PW'(NREQ - 1);
         wait_cnt     <= '0;
         resp_pending <= '0;
      end else begin
         if (found) rr_ptr <= win_idx;
         resp_pending <= rd_grant ? grant : '0;
         // Count only cycles where a reader was actually passed over for a writer.
         if (!(|r_set) || rd_grant)
            wait_cnt <= '0;
         else if (found && (wait_cnt != MAX_WAIT[3:0]))
            wait_cnt <= wait_cnt + 4'd1;
      end
   end

   assign resp_valid   = resp_pending;
   assign resp_rs_data = rf_rs_out;
   assign resp_rt_data = rf_rt_out;

endmodule
